// File: rtl/ram_frame_reader.sv
// ram_frame_reader: sweeps every RAM address on a start pulse and streams the words out valid/ready.
// Latency: first m_valid RD_LATENCY+1 cycles after start is accepted, then one word per cycle.
// Backpressure: m_ready low holds the output word; credit gating stalls issue so no word is lost.
//
// Ports:
//   clk, rst_n           single clock, asynchronous active-low reset
//   start / busy / done  frame control: start pulse in, busy while reading, done one cycle after m_last transfer
//   rd_address, rd_data  registered read address to the RAM, read data back after RD_LATENCY cycles
//   m_data, m_valid, m_ready, m_last  output stream, m_last flags word N-1
//
// Build option: BIT_REVERSE_EN -- issue addresses in bit-reversed counter order.
module ram_frame_reader #(
  parameter int word_width    = 4,
  parameter int address_width = 3,
  parameter int RD_LATENCY    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic [address_width-1:0] rd_address,
  input  logic [word_width-1:0]    rd_data,
  output logic [word_width-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     done
);

  localparam int N     = 2 ** address_width;
  localparam int DEPTH = RD_LATENCY + 2;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(2 * DEPTH + 1);
  localparam logic [CW-1:0]            DEPTH_C  = CW'(DEPTH);
  localparam logic [address_width:0]   LAST_IDX = (address_width + 1)'(N - 1);
  localparam logic [PW-1:0]            PTR_MAX  = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                   state;
  logic [address_width:0]   issue_cnt;
  logic [RD_LATENCY-1:0]    tags;       // one bit per outstanding RAM read
  logic [address_width-1:0] push_idx;   // index of the next word entering the FIFO
  logic [word_width-1:0]    fifo_dat [DEPTH];
  logic                     fifo_lst [DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [CW-1:0]            fifo_count;
  logic [CW-1:0]            in_flight;
  logic                     credit;
  logic                     issue;
  logic                     push;
  logic                     pop;
  logic [address_width-1:0] issue_addr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + CW'(tags[i]);
    end
  end

  // Every issued read is guaranteed a FIFO slot when its data returns.
  assign credit = (fifo_count + in_flight) < DEPTH_C;
  // Address 0 goes out on the accept edge itself, so the first word is not delayed a cycle.
  assign issue  = ((state == IDLE) && start) || ((state == READ) && credit);
  assign push   = tags[RD_LATENCY-1];

  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = fifo_dat[rd_ptr];
  assign m_last  = m_valid && fifo_lst[rd_ptr];

  always_comb begin
    issue_addr = '0;
`ifdef BIT_REVERSE_EN
    for (int i = 0; i < address_width; i++) begin
      issue_addr[i] = issue_cnt[address_width-1-i];
    end
`else
    issue_addr = issue_cnt[address_width-1:0];
`endif
  end

  // Frame control FSM and read issue pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_address <= '0;
      issue_cnt  <= '0;
      push_idx   <= '0;
      tags       <= '0;
    end else begin
      done <= 1'b0;
      tags[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tags[i] <= tags[i-1];
      end
      if (push) begin
        push_idx <= push_idx + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state      <= READ;
            busy       <= 1'b1;
            rd_address <= '0;
            issue_cnt  <= (address_width + 1)'(1);
            push_idx   <= '0;
          end
        end
        READ: begin
          if (credit) begin
            rd_address <= issue_addr;
            issue_cnt  <= issue_cnt + 1'b1;
            if (issue_cnt == LAST_IDX) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            rd_address <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skid FIFO absorbing returned read data; the last flag travels with the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_dat[i] <= '0;
        fifo_lst[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_dat[wr_ptr] <= rd_data;
        fifo_lst[wr_ptr] <= &push_idx;
        wr_ptr           <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

endmodule
